// File: rtl/trolley_pio_pkg.sv
`default_nettype none
// ============================================================================
//  trolley_pio_pkg
//  Register map and parameter encodings shared by the trolley input PIO.
//  Rev 1.0
// ============================================================================
package trolley_pio_pkg;

    localparam logic [1:0] c_addr_data    = 2'd0;
    localparam logic [1:0] c_addr_rsvd    = 2'd1;
    localparam logic [1:0] c_addr_irqmask = 2'd2;
    localparam logic [1:0] c_addr_edgecap = 2'd3;

    localparam int c_edge_rising  = 0;
    localparam int c_edge_falling = 1;
    localparam int c_edge_any     = 2;

    localparam int c_irq_level = 0;
    localparam int c_irq_edge  = 1;

endpackage
`default_nettype wire

// File: rtl/trolley_debounce.sv
`default_nettype none
// ============================================================================
//  trolley_debounce
//  One-bit synchroniser followed by a stable-count debouncer.
//  Rev 1.0
// ============================================================================
module trolley_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_level
);

    localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_level;
    logic                   w_sync;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign o_level = r_level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Counter tops out at DEBOUNCE_CYCLES-1, where it is cleared on acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_sync == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_cnt   <= '0;
            r_level <= w_sync;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/trolley_input_pio.sv
`default_nettype none
// ============================================================================
//  trolley_input_pio
//  Debounced key/switch input port with edge capture and IRQ, Avalon-MM slave.
//  Rev 1.0
// ============================================================================
module trolley_input_pio
    import trolley_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1,
    parameter int IRQ_MODE        = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq,
    output logic [31:0]      readdata
);

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] r_level_d;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic [31:0]      w_rd_mux;
    logic             w_unused_wdata;

    assign w_unused_wdata = &{1'b0, writedata};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            trolley_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .reset_n (reset_n),
                .i_raw   (in_port[gi]),
                .o_level (w_level[gi])
            );
        end
    endgenerate

    generate
        if (EDGE_TYPE == c_edge_rising) begin : g_edge_rise
            assign w_edge = w_level & ~r_level_d;
        end else if (EDGE_TYPE == c_edge_falling) begin : g_edge_fall
            assign w_edge = ~w_level & r_level_d;
        end else begin : g_edge_any
            assign w_edge = w_level ^ r_level_d;
        end
    endgenerate

    assign w_wr  = chipselect & ~write_n;
    assign w_clr = (w_wr && address == c_addr_edgecap) ? writedata[WIDTH-1:0] : '0;

    // A fresh edge overrides a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level_d <= '0;
            r_edgecap <= '0;
            r_irqmask <= '0;
        end else begin
            r_level_d <= w_level;
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
            if (w_wr && address == c_addr_irqmask) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            c_addr_data:    w_rd_mux = 32'(w_level);
            c_addr_irqmask: w_rd_mux = 32'(r_irqmask);
            c_addr_edgecap: w_rd_mux = 32'(r_edgecap);
            default:        w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= w_rd_mux;
        end
    end

    generate
        if (IRQ_MODE == c_irq_level) begin : g_irq_level
            assign irq = |(w_level & r_irqmask);
        end else begin : g_irq_edge
            assign irq = |(r_edgecap & r_irqmask);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_trolley_input_pio.sv
`default_nettype none
// ============================================================================
//  tb_trolley_input_pio
//  Directed bench over three parameterisations sharing one bus and input port.
//  Rev 1.0
// ============================================================================
module tb_trolley_input_pio;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;

    logic [31:0] rd_e0, rd_lv, rd_e1;
    logic        irq_e0, irq_lv, irq_e1;

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rising-edge capture, edge irq
    trolley_input_pio #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .IRQ_MODE(1)) u_dut_e0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .irq(irq_e0), .readdata(rd_e0));

    // level irq
    trolley_input_pio #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IRQ_MODE(0)) u_dut_lv (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .irq(irq_lv), .readdata(rd_lv));

    // falling-edge capture, edge irq
    trolley_input_pio #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IRQ_MODE(1)) u_dut_e1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .irq(irq_e1), .readdata(rd_e1));

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_port = 4'h0; address = 2'd0;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({irq_e0, irq_lv, irq_e1} !== 3'b000) begin
            n_bad++; $display("FAIL reset_irq_during: got %b expected 000", {irq_e0, irq_lv, irq_e1});
        end
        n_cmp++;
        if ({rd_e0, rd_lv, rd_e1} !== 96'h0) begin
            n_bad++; $display("FAIL reset_readdata_during: got %h %h %h expected 0", rd_e0, rd_lv, rd_e1);
        end
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            @(negedge clk);
            n_cmp++;
            if ((rd_e0 | rd_lv | rd_e1) !== 32'h0) begin
                n_bad++; $display("FAIL reset_read_addr%0d: got %h %h %h expected 0", a, rd_e0, rd_lv, rd_e1);
            end
        end
        n_cmp++;
        if ({irq_e0, irq_lv, irq_e1} !== 3'b000) begin
            n_bad++; $display("FAIL reset_irq_after: got %b expected 000", {irq_e0, irq_lv, irq_e1});
        end
    endtask

    task automatic test_debounce();
        logic [31:0] seen;
        int          lat;
        address = 2'd0;
        in_port = 4'h1;
        repeat (3) @(negedge clk);
        in_port = 4'h0;
        seen = 32'h0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | rd_e0;
        end
        n_cmp++;
        if (seen !== 32'h0) begin
            n_bad++; $display("FAIL glitch_reject: got %h expected 00000000", seen);
        end
        in_port = 4'h1;
        lat = 0;
        while (rd_e0 !== 32'h1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (rd_e0 !== 32'h1) begin
            n_bad++; $display("FAIL debounce_accept: got %h after %0d cycles expected 00000001 within 8", rd_e0, lat);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rd_lv !== 32'h1) begin
            n_bad++; $display("FAIL debounce_hold: got %h expected 00000001", rd_lv);
        end
    endtask

    task automatic test_edge_irq();
        bus_write(2'd2, 32'h1);
        bus_write(2'd3, 32'hF);
        address = 2'd3;
        @(negedge clk);
        n_cmp++;
        if (rd_e0 !== 32'h0 || irq_e0 !== 1'b0) begin
            n_bad++; $display("FAIL edgecap_cleared: got %h irq %b expected 0 irq 0", rd_e0, irq_e0);
        end
        in_port = 4'h0;
        repeat (10) @(negedge clk);
        in_port = 4'h1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (rd_e0 !== 32'h1 || irq_e0 !== 1'b1) begin
            n_bad++; $display("FAIL rise_capture: got %h irq %b expected 1 irq 1", rd_e0, irq_e0);
        end
        n_cmp++;
        if (rd_e1 !== 32'h1 || irq_e1 !== 1'b1) begin
            n_bad++; $display("FAIL fall_capture: got %h irq %b expected 1 irq 1", rd_e1, irq_e1);
        end
        bus_write(2'd3, 32'h1);
        n_cmp++;
        if (irq_e0 !== 1'b0) begin
            n_bad++; $display("FAIL irq_after_clear: got %b expected 0", irq_e0);
        end
        @(negedge clk);
        n_cmp++;
        if (rd_e0 !== 32'h0) begin
            n_bad++; $display("FAIL edgecap_w1c: got %h expected 00000000", rd_e0);
        end
    endtask

    task automatic test_set_wins();
        in_port = 4'h5;
        repeat (6) @(negedge clk);
        bus_write(2'd3, 32'h4);
        @(negedge clk);
        n_cmp++;
        if (rd_e0 !== 32'h4) begin
            n_bad++; $display("FAIL set_beats_clear: got %h expected 00000004", rd_e0);
        end
        bus_write(2'd3, 32'h4);
        @(negedge clk);
        n_cmp++;
        if (rd_e0 !== 32'h0) begin
            n_bad++; $display("FAIL clear_after_set: got %h expected 00000000", rd_e0);
        end
    endtask

    task automatic test_level_irq();
        bus_write(2'd2, 32'h4);
        in_port = 4'h4;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (irq_lv !== 1'b1) begin
            n_bad++; $display("FAIL level_irq_on: got %b expected 1", irq_lv);
        end
        in_port = 4'h0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (irq_lv !== 1'b1) begin
            n_bad++; $display("FAIL level_irq_debouncing: got %b expected 1", irq_lv);
        end
        @(negedge clk);
        n_cmp++;
        if (irq_lv !== 1'b0) begin
            n_bad++; $display("FAIL level_irq_off: got %b expected 0", irq_lv);
        end
        in_port = 4'hF;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (irq_lv !== 1'b1) begin
            n_bad++; $display("FAIL level_irq_all: got %b expected 1", irq_lv);
        end
        bus_write(2'd2, 32'hFFFF_FFF0);
        n_cmp++;
        if (irq_lv !== 1'b0) begin
            n_bad++; $display("FAIL level_irq_masked: got %b expected 0", irq_lv);
        end
        address = 2'd2;
        @(negedge clk);
        n_cmp++;
        if (rd_lv !== 32'h0) begin
            n_bad++; $display("FAIL irqmask_upper_ignored: got %h expected 00000000", rd_lv);
        end
        bus_write(2'd1, 32'hF);
        address = 2'd1;
        @(negedge clk);
        n_cmp++;
        if (rd_lv !== 32'h0) begin
            n_bad++; $display("FAIL reserved_reads_zero: got %h expected 00000000", rd_lv);
        end
        bus_write(2'd0, 32'h0);
        address = 2'd0;
        @(negedge clk);
        n_cmp++;
        if (rd_lv !== 32'hF) begin
            n_bad++; $display("FAIL data_write_ignored: got %h expected 0000000f", rd_lv);
        end
    endtask

    task automatic test_reset_mid();
        in_port = 4'h0;
        repeat (10) @(negedge clk);
        in_port = 4'hF;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        address = 2'd0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (rd_e1 !== 32'h0) begin
            n_bad++; $display("FAIL reset_discards_count: got %h expected 00000000", rd_e1);
        end
        @(negedge clk);
        n_cmp++;
        if (rd_e1 !== 32'hF) begin
            n_bad++; $display("FAIL reset_full_debounce: got %h expected 0000000f", rd_e1);
        end
        repeat (3) @(negedge clk);
        address = 2'd3;
        @(negedge clk);
        n_cmp++;
        if (rd_e1 !== 32'h0 || irq_e1 !== 1'b0) begin
            n_bad++; $display("FAIL reset_no_fall_capture: got %h irq %b expected 0 irq 0", rd_e1, irq_e1);
        end
        n_cmp++;
        if (rd_e0 !== 32'hF || irq_e0 !== 1'b0) begin
            n_bad++; $display("FAIL reset_rise_capture: got %h irq %b expected f irq 0", rd_e0, irq_e0);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_edge_irq();
        test_set_wins();
        test_level_irq();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
